// File: rtl/spi_ip_crc_checker.sv
// Receive-side CRC checker: recomputes CRC8/CRC16 over the data words of a
// serial frame, captures the trailing CRC word and flags a mismatch at frame end.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no frame in progress; valid bits ignored, results held
// ST_DATA  | shifting data words through the CRC register
// ST_CRC   | shifting the received CRC word into the rx register
module spi_ip_crc_checker #(
  parameter logic [15:0] PARAM_CRC_INIT = 16'h0000
) (
  input  logic        cs_clk_i,
  input  logic        cs_rst_n_i,
  input  logic        cs_frame_start_i,
  input  logic        cs_crc_size_i,
  input  logic [15:0] cs_crc_poly_i,
  input  logic [7:0]  cs_data_words_i,
  input  logic        cs_bit_i,
  input  logic        cs_bit_valid_i,
  output logic        cs_busy_o,
  output logic        cs_done_o,
  output logic        cs_crc_err_o,
  output logic [15:0] cs_crc_calc_o,
  output logic [15:0] cs_crc_rx_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        size_q, size_d;
  logic [15:0] poly_q, poly_d;
  logic [7:0]  words_q, words_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] rx_q, rx_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        last_bit;
  logic        last_word;
  logic        fb;
  logic [15:0] crc_step;
  logic [15:0] rx_shift;
  logic        crc_match;

  assign last_bit  = size_q ? (bit_cnt_q == 4'd15) : (bit_cnt_q == 4'd7);
  assign last_word = (word_cnt_q == (words_q - 8'd1));
  assign rx_shift  = {rx_q[14:0], cs_bit_i};

  // Compare includes the bit being shifted in on this cycle.
  assign crc_match = size_q ? (crc_q == rx_shift) : (crc_q[7:0] == rx_shift[7:0]);

  always_comb begin
    fb       = 1'b0;
    crc_step = crc_q;
    if (size_q) begin
      fb       = cs_bit_i ^ crc_q[15];
      crc_step = {crc_q[14:0], 1'b0} ^ (poly_q & {16{fb}});
    end else begin
      fb       = cs_bit_i ^ crc_q[7];
      crc_step = {8'h00, {crc_q[6:0], 1'b0} ^ (poly_q[7:0] & {8{fb}})};
    end
  end

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    poly_d     = poly_q;
    words_d    = words_q;
    crc_d      = crc_q;
    rx_d       = rx_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    done_d     = 1'b0;
    err_d      = err_q;

    if (cs_frame_start_i) begin
      // A start in any state wins over a valid bit and aborts a busy frame.
      size_d     = cs_crc_size_i;
      poly_d     = cs_crc_poly_i;
      words_d    = cs_data_words_i;
      crc_d      = cs_crc_size_i ? PARAM_CRC_INIT : {8'h00, PARAM_CRC_INIT[7:0]};
      rx_d       = 16'h0000;
      bit_cnt_d  = 4'd0;
      word_cnt_d = 8'd0;
      err_d      = 1'b0;
      state_d    = (cs_data_words_i == 8'd0) ? ST_CRC : ST_DATA;
    end else begin
      case (state_q)
        ST_DATA: begin
          if (cs_bit_valid_i) begin
            crc_d = crc_step;
            if (last_bit) begin
              bit_cnt_d  = 4'd0;
              word_cnt_d = word_cnt_q + 8'd1;
              if (last_word) begin
                state_d = ST_CRC;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ST_CRC: begin
          if (cs_bit_valid_i) begin
            rx_d = rx_shift;
            if (last_bit) begin
              bit_cnt_d = 4'd0;
              err_d     = ~crc_match;
              done_d    = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge cs_clk_i) begin
    if (!cs_rst_n_i) begin
      state_q    <= ST_IDLE;
      size_q     <= 1'b0;
      poly_q     <= 16'h0000;
      words_q    <= 8'd0;
      crc_q      <= PARAM_CRC_INIT;
      rx_q       <= 16'h0000;
      bit_cnt_q  <= 4'd0;
      word_cnt_q <= 8'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      poly_q     <= poly_d;
      words_q    <= words_d;
      crc_q      <= crc_d;
      rx_q       <= rx_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cs_busy_o     = (state_q != ST_IDLE);
  assign cs_done_o     = done_q;
  assign cs_crc_err_o  = err_q;
  assign cs_crc_calc_o = crc_q;
  assign cs_crc_rx_o   = rx_q;

endmodule

// File: tb/tb_spi_ip_crc_checker.sv
// Bench for spi_ip_crc_checker: directed frames plus randomized frames checked
// against a word-wise CRC reference model.
module tb_spi_ip_crc_checker;

  localparam logic [15:0] INIT = 16'h0000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        size_i;
  logic [15:0] poly_i;
  logic [7:0]  words_i;
  logic        bit_i;
  logic        valid;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] calc;
  logic [15:0] rx;

  int n_cmp = 0;
  int n_mis = 0;
  int done_seen = 0;

  logic [15:0] data_mem [0:255];

  spi_ip_crc_checker #(.PARAM_CRC_INIT(INIT)) dut (
    .cs_clk_i         (clk),
    .cs_rst_n_i       (rst_n),
    .cs_frame_start_i (start),
    .cs_crc_size_i    (size_i),
    .cs_crc_poly_i    (poly_i),
    .cs_data_words_i  (words_i),
    .cs_bit_i         (bit_i),
    .cs_bit_valid_i   (valid),
    .cs_busy_o        (busy),
    .cs_done_o        (done),
    .cs_crc_err_o     (err),
    .cs_crc_calc_o    (calc),
    .cs_crc_rx_o      (rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word-at-a-time CRC: xor the whole word into the register, then divide.
  function automatic logic [15:0] model_crc(input bit sz, input logic [15:0] poly, input int nw);
    logic [15:0] mask;
    logic [15:0] c;
    logic        top;
    int          w;
    w    = sz ? 16 : 8;
    mask = sz ? 16'hffff : 16'h00ff;
    c    = INIT & mask;
    for (int i = 0; i < nw; i++) begin
      c = c ^ (data_mem[i] & mask);
      for (int k = 0; k < w; k++) begin
        top = sz ? c[15] : c[7];
        c   = ((c << 1) & mask) ^ (top ? (poly & mask) : 16'h0000);
      end
    end
    return c;
  endfunction

  task automatic run_frame(input bit sz, input logic [15:0] poly, input int nw,
                           input logic [15:0] rx_crc, input int gmin, input int gmax,
                           input int abort_at);
    int          w;
    int          total;
    int          idx;
    int          pos;
    int          d0;
    logic        b;
    logic        exp_err;
    logic [15:0] exp_crc;
    logic [15:0] exp_rx;
    logic [15:0] init_m;
    w       = sz ? 16 : 8;
    total   = (nw + 1) * w;
    exp_crc = model_crc(sz, poly, nw);
    exp_rx  = sz ? rx_crc : {8'h00, rx_crc[7:0]};
    exp_err = (exp_rx != exp_crc);
    init_m  = sz ? INIT : {8'h00, INIT[7:0]};
    d0      = done_seen;

    @(negedge clk);
    start   = 1'b1;
    size_i  = sz;
    poly_i  = poly;
    words_i = nw[7:0];
    valid   = 1'b1;
    bit_i   = 1'($urandom);
    @(negedge clk);
    start   = 1'b0;
    valid   = 1'b0;
    size_i  = 1'($urandom);
    poly_i  = 16'($urandom);
    words_i = 8'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_clr_at_start", 32'(err), 32'd0);
    chk("calc_init", 32'(calc), 32'(init_m));
    chk("rx_clr_at_start", 32'(rx), 32'd0);

    for (int k = 0; k < total; k++) begin
      if (k == abort_at) return;
      repeat ($urandom_range(gmax, gmin)) @(negedge clk);
      idx   = k / w;
      pos   = w - 1 - (k % w);
      b     = (idx < nw) ? data_mem[idx][pos] : rx_crc[pos];
      bit_i = b;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      bit_i = 1'($urandom);
      if (k == total - 2) begin
        chk("done_early", 32'(done), 32'd0);
        chk("busy_before_last", 32'(busy), 32'd1);
      end
    end

    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("crc_err", 32'(err), 32'(exp_err));
    chk("crc_calc", 32'(calc), 32'(exp_crc));
    chk("crc_rx", 32'(rx), 32'(exp_rx));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("err_held", 32'(err), 32'(exp_err));
    chk("calc_held", 32'(calc), 32'(exp_crc));
    chk("done_count", 32'(done_seen), 32'(d0 + 1));
  endtask

  initial begin
    int          d0;
    logic [15:0] c_hold;
    logic [15:0] r_hold;
    rst_n   = 1'b0;
    start   = 1'b0;
    size_i  = 1'b0;
    poly_i  = 16'h0000;
    words_i = 8'd0;
    bit_i   = 1'b0;
    valid   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_calc", 32'(calc), 32'(INIT));
    chk("rst_rx", 32'(rx), 32'd0);
    rst_n = 1'b1;

    // Bits offered while idle must not touch anything.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid = 1'b1;
      bit_i = 1'($urandom);
    end
    @(negedge clk);
    valid = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_calc", 32'(calc), 32'(INIT));
    chk("idle_rx", 32'(rx), 32'd0);

    data_mem[0] = 16'h0001;
    run_frame(1'b0, 16'h0007, 1, 16'h0007, 0, 0, -1);
    chk("crc8_good_calc", 32'(calc), 32'h0007);
    chk("crc8_good_err", 32'(err), 32'd0);

    run_frame(1'b0, 16'h0007, 1, 16'h0006, 0, 0, -1);
    chk("crc8_bad_err", 32'(err), 32'd1);
    c_hold = calc;
    r_hold = rx;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      valid = 1'b1;
      bit_i = 1'($urandom);
    end
    @(negedge clk);
    valid = 1'b0;
    chk("err_held_idle", 32'(err), 32'd1);
    chk("calc_held_idle", 32'(calc), 32'(c_hold));
    chk("rx_held_idle", 32'(rx), 32'(r_hold));

    run_frame(1'b0, 16'h0007, 1, 16'h0007, 0, 0, -1);
    chk("crc8_recover_err", 32'(err), 32'd0);

    run_frame(1'b0, 16'hFF07, 1, 16'h0007, 2, 2, -1);
    chk("crc8_gapped_calc", 32'(calc), 32'h0007);
    chk("crc8_gapped_err", 32'(err), 32'd0);

    data_mem[0] = 16'h0001;
    run_frame(1'b1, 16'h1021, 1, 16'h1021, 0, 0, -1);
    chk("crc16_good_calc", 32'(calc), 32'h1021);
    chk("crc16_good_err", 32'(err), 32'd0);
    run_frame(1'b1, 16'h1021, 1, 16'h1020, 0, 0, -1);
    chk("crc16_bad_err", 32'(err), 32'd1);

    run_frame(1'b1, 16'h1021, 0, 16'h0000, 0, 0, -1);
    chk("zero_words_good", 32'(err), 32'd0);
    run_frame(1'b1, 16'h1021, 0, 16'h0001, 0, 0, -1);
    chk("zero_words_bad", 32'(err), 32'd1);

    // Restart after 5 bits: only the second frame may produce done.
    d0 = done_seen;
    data_mem[0] = 16'h0001;
    run_frame(1'b0, 16'h0007, 1, 16'h0007, 0, 0, 5);
    run_frame(1'b0, 16'h0007, 1, 16'h0007, 0, 0, -1);
    chk("abort_good_err", 32'(err), 32'd0);
    chk("abort_done_count", 32'(done_seen), 32'(d0 + 1));

    // Reset in the CRC phase; start and valid in the same cycle lose to reset.
    d0 = done_seen;
    run_frame(1'b1, 16'h1021, 0, 16'hA5A5, 0, 0, 5);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_calc", 32'(calc), 32'(INIT));
    chk("midrst_rx", 32'(rx), 32'd0);
    repeat (20) @(negedge clk);
    chk("midrst_no_done", 32'(done_seen), 32'(d0));

    for (int f = 0; f < 40; f++) begin
      bit          sz;
      int          nw;
      logic [15:0] poly;
      logic [15:0] good;
      logic [15:0] rxw;
      sz   = 1'($urandom);
      nw   = $urandom_range(6, 0);
      poly = 16'($urandom);
      for (int i = 0; i < nw; i++) data_mem[i] = 16'($urandom);
      good = model_crc(sz, poly, nw);
      rxw  = good;
      if ($urandom_range(1, 0) == 1)
        rxw = rxw ^ (16'h0001 << $urandom_range(sz ? 15 : 7, 0));
      if (!sz) rxw[15:8] = 8'($urandom);
      run_frame(sz, poly, nw, rxw, 0, 3, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
